svf_tdm: RTL and testbench

- Time-multiplexed, parametrised Chamberlin state-variable filter that serves NUM_CH independent voices through one shared shift/add datapath.
- Per-channel bp/lp state lives in internal register arrays. Each accepted sample runs a 4-cycle HP -> BP -> LP -> writeback sequence, and the block returns one selectable response per request.
- Sits between the voice mixer and the output DAC path. It replaces per-voice single-channel filters.

---
 rtl/svf_tdm.sv | 182 ++++++++++++++++++
 tb/tb_svf_tdm.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/svf_tdm.sv
//------------------------------------------------------------------------------
// svf_tdm : time-multiplexed Chamberlin state-variable filter, NUM_CH voices
//           sharing one saturating HP -> BP -> LP datapath.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module svf_tdm #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int NUM_CH = 3,
    parameter int FC_W   = 6,
    parameter int Q_W    = 2,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_sample,
    input  logic [FC_W-1:0]   in_fc,
    input  logic [Q_W-1:0]    in_q,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data
);

    localparam int IW  = DATA_W + FRAC_W;
    // Two guard bits cover xs - lp - qmul(bp) before clamping.
    localparam int EW  = IW + 2;
    localparam int FSH = FC_W + 3;

    localparam logic signed [IW-1:0] SAT_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] SAT_MIN = {1'b1, {(IW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S_HP = 2'd1,
        S_BP = 2'd2,
        S_LP = 2'd3
    } state_t;

    function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
        if (v[EW-1:IW-1] == {(EW-IW+1){v[EW-1]}}) return v[IW-1:0];
        return v[EW-1] ? SAT_MIN : SAT_MAX;
    endfunction

    function automatic logic signed [EW-1:0] ext(input logic signed [IW-1:0] v);
        return EW'(v);
    endfunction

    function automatic logic signed [EW-1:0] fmul(input logic signed [IW-1:0] v,
                                                  input logic [FC_W-1:0]   f);
        logic signed [IW+FC_W:0] p;
        p = v * $signed({1'b0, f});
        return EW'(p >>> FSH);
    endfunction

    function automatic logic signed [EW-1:0] qmul(input logic signed [IW-1:0] v,
                                                  input logic [Q_W-1:0]    d);
        logic signed [IW+Q_W:0] p;
        p = v * $signed({1'b0, d});
        return EW'(p >>> Q_W);
    endfunction

    state_t state_q, state_d;

    logic [CH_W-1:0]       ch_q;
    logic [DATA_W-1:0]     sample_q;
    logic [FC_W-1:0]       fc_q;
    logic [Q_W-1:0]        q_q;
    logic [1:0]            mode_q;
    logic signed [IW-1:0]  hp_q;
    logic signed [IW-1:0]  bpn_q;
    logic signed [IW-1:0]  bp_q [NUM_CH];
    logic signed [IW-1:0]  lp_q [NUM_CH];
    logic                  out_valid_q;
    logic [CH_W-1:0]       out_ch_q;
    logic [DATA_W-1:0]     out_data_q;

    logic                  ch_ok;
    logic signed [IW-1:0]  bp_cur, lp_cur;
    logic signed [EW-1:0]  xs;
    logic signed [IW-1:0]  hp_d, bpn_d, lpn_d, notch, sel;
    logic [DATA_W-1:0]     res_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = S_HP;
            S_HP:    state_d = S_BP;
            S_BP:    state_d = S_LP;
            S_LP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range channels run on a zero state and produce a zero result.
    always_comb begin
        ch_ok  = ({1'b0, ch_q} < (CH_W+1)'(NUM_CH));
        bp_cur = '0;
        lp_cur = '0;
        if (ch_ok) begin
            bp_cur = bp_q[ch_q];
            lp_cur = lp_q[ch_q];
        end
        xs    = {{(EW-IW){sample_q[DATA_W-1]}}, sample_q, {FRAC_W{1'b0}}};
        hp_d  = sat(xs - ext(lp_cur) - qmul(bp_cur, q_q));
        bpn_d = sat(ext(bp_cur) + fmul(hp_q, fc_q));
        lpn_d = sat(ext(lp_cur) + fmul(bpn_q, fc_q));
        notch = sat(ext(hp_q) + ext(lpn_d));
        case (mode_q)
            2'd0:    sel = lpn_d;
            2'd1:    sel = bpn_q;
            2'd2:    sel = hp_q;
            default: sel = notch;
        endcase
        res_d = ch_ok ? DATA_W'(sel >>> FRAC_W) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q        <= '0;
            sample_q    <= '0;
            fc_q        <= '0;
            q_q         <= '0;
            mode_q      <= '0;
            hp_q        <= '0;
            bpn_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                bp_q[i] <= '0;
                lp_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ch_q     <= in_ch;
                        sample_q <= in_sample;
                        fc_q     <= in_fc;
                        q_q      <= in_q;
                        mode_q   <= in_mode;
                    end
                end
                S_HP: hp_q  <= hp_d;
                S_BP: bpn_q <= bpn_d;
                S_LP: begin
                    if (ch_ok) begin
                        bp_q[ch_q] <= bpn_q;
                        lp_q[ch_q] <= lpn_d;
                    end
                    out_data_q  <= res_d;
                    out_ch_q    <= ch_q;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_svf_tdm.sv
//------------------------------------------------------------------------------
// tb_svf_tdm : directed self-checking bench for svf_tdm (3 channels, 8-bit).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_svf_tdm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_ch;
    logic [7:0] in_sample;
    logic [5:0] in_fc;
    logic [1:0] in_q;
    logic [1:0] in_mode;
    logic       out_valid;
    logic [1:0] out_ch;
    logic [7:0] out_data;

    int nvec = 0;
    int nerr = 0;
    int bpm [3];
    int lpm [3];
    int last_data;

    svf_tdm #(.DATA_W(8), .FRAC_W(4), .NUM_CH(3), .FC_W(6), .Q_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_sample(in_sample), .in_fc(in_fc), .in_q(in_q), .in_mode(in_mode),
        .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int msat(input int v);
        if (v > 2047)  return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Reference filter step on integers; updates per-channel state.
    task automatic mstep(input int ch, input int smp, input int fc, input int q,
                         input int mode, output int y);
        int bp, lp, hp, bpn, lpn, s;
        bp  = (ch < 3) ? bpm[ch] : 0;
        lp  = (ch < 3) ? lpm[ch] : 0;
        hp  = msat(smp * 16 - lp - ((bp * q) >>> 2));
        bpn = msat(bp + ((hp * fc) >>> 9));
        lpn = msat(lp + ((bpn * fc) >>> 9));
        case (mode)
            0:       s = lpn;
            1:       s = bpn;
            2:       s = hp;
            default: s = msat(hp + lpn);
        endcase
        if (ch < 3) begin
            bpm[ch] = bpn;
            lpm[ch] = lpn;
            y = s >>> 4;
        end else begin
            y = 0;
        end
    endtask

    task automatic req(input int ch, input int smp, input int fc, input int q,
                       input int mode, input string tag);
        int n;
        int exp;
        @(negedge clk);
        in_ch = 2'(ch); in_sample = 8'(smp); in_fc = 6'(fc);
        in_q = 2'(q); in_mode = 2'(mode); in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/ready"}, int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        mstep(ch, smp, fc, q, mode, exp);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk({tag, "/valid"}, int'(out_valid), (k == 3) ? 1 : 0);
        end
        chk({tag, "/ready_back"}, int'(in_ready), 1);
        chk({tag, "/ch"}, int'(out_ch), ch);
        chk({tag, "/data"}, int'($signed(out_data)), exp);
        last_data = int'($signed(out_data));
    endtask

    initial begin
        int  acc, rdy, y, idx;
        int  expq [3];
        int  bch [3], bsm [3], bfc [3], bq [3], bmd [3];

        rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_sample = '0;
        in_fc = '0; in_q = '0; in_mode = '0;
        for (int i = 0; i < 3; i++) begin bpm[i] = 0; lpm[i] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst/ready", int'(in_ready), 1);
        chk("rst/valid", int'(out_valid), 0);
        chk("rst/data", int'(out_data), 0);
        chk("rst/ch", int'(out_ch), 0);

        req(0, 64, 63, 0, 1, "t1_ch0_bp");
        chk("t1/plan", last_data, 7);
        req(1, 64, 63, 0, 0, "t2_ch1_lp");
        chk("t2a/plan", last_data, 0);
        req(0, 64, 63, 0, 0, "t2_ch0_lp");
        chk("t2b/plan", last_data, 2);

        // Back-to-back with in_valid held high.
        bch = '{0, 1, 2}; bsm = '{20, -50, 90}; bfc = '{40, 63, 10};
        bq  = '{1, 2, 3}; bmd = '{2, 3, 1};
        @(negedge clk);
        acc = 0;
        in_ch = 2'(bch[0]); in_sample = 8'(bsm[0]); in_fc = 6'(bfc[0]);
        in_q = 2'(bq[0]); in_mode = 2'(bmd[0]); in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rdy = int'(in_ready);
            @(posedge clk);
            #1;
            if (rdy == 1 && in_valid) begin
                chk("b2b/accept_cycle", c, 4 * acc);
                mstep(bch[acc], bsm[acc], bfc[acc], bq[acc], bmd[acc], y);
                expq[acc] = y;
                acc++;
                if (acc < 3) begin
                    in_ch = 2'(bch[acc]); in_sample = 8'(bsm[acc]); in_fc = 6'(bfc[acc]);
                    in_q = 2'(bq[acc]); in_mode = 2'(bmd[acc]);
                end else begin
                    in_valid = 1'b0;
                end
            end
            chk("b2b/valid", int'(out_valid), (c % 4 == 3) ? 1 : 0);
            chk("b2b/ready", int'(in_ready), (c % 4 == 3) ? 1 : 0);
            if (c % 4 == 3) begin
                idx = c / 4;
                chk("b2b/data", int'($signed(out_data)), expq[idx]);
                chk("b2b/ch", int'(out_ch), bch[idx]);
            end
            @(negedge clk);
        end
        chk("b2b/accepts", acc, 3);

        // Saturation on channel 2.
        for (int i = 0; i < 300; i++) begin
            req(2, 127, 63, 3, 3, "sat_pos");
            chk("sat_pos/sign", int'(last_data >= 0), 1);
        end
        req(2, 127, 63, 3, 0, "sat_pos_lp");
        chk("sat_pos_lp/settle", int'(last_data >= 126 && last_data <= 127), 1);
        for (int i = 0; i < 300; i++) begin
            req(2, -128, 63, 3, 3, "sat_neg");
            chk("sat_neg/sign", int'(last_data < 0), 1);
        end
        req(2, -128, 63, 3, 0, "sat_neg_lp");
        chk("sat_neg_lp/settle", int'(last_data >= -128 && last_data <= -127), 1);

        // Reset while the sequence is in S_BP.
        @(negedge clk);
        in_ch = 2'd0; in_sample = 8'd64; in_fc = 6'd63; in_q = 2'd0;
        in_mode = 2'd1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst/valid", int'(out_valid), 0);
        chk("midrst/ready", int'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            bpm[i] = 0;
            lpm[i] = 0;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("midrst/held_valid", int'(out_valid), 0);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("midrst/no_pulse", int'(out_valid), 0);
            chk("midrst/idle", int'(in_ready), 1);
        end
        req(0, 64, 63, 0, 1, "post_rst_bp");
        chk("post_rst/plan", last_data, 7);

        // Out-of-range channel, then confirm real channels untouched.
        req(3, 100, 63, 0, 2, "oor_ch3");
        chk("oor/plan_data", last_data, 0);
        chk("oor/plan_ch", int'(out_ch), 3);
        req(1, 64, 63, 0, 0, "rep_ch1_lp");
        chk("rep_a/plan", last_data, 0);
        req(0, 64, 63, 0, 0, "rep_ch0_lp");
        chk("rep_b/plan", last_data, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
